// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit pipelined CPU: widths, MEM stage states,
// the MEM/WB pipeline bundle and the opcodes of the memory/halt instructions.
package cpu_pkg;

    localparam int CPU_DW = 16;
    localparam int CPU_AW = 16;
    localparam int CPU_RW = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        HALTED
    } dmem_state_e;

    typedef struct packed {
        logic              valid;
        logic              reg_wr;
        logic [CPU_RW-1:0] dst;
        logic [CPU_DW-1:0] data;
        logic [15:0]       inst;
        logic              halt;
    } mem_wb_t;

    localparam logic [3:0] OP_LW  = 4'h8;
    localparam logic [3:0] OP_SW  = 4'h9;
    localparam logic [3:0] OP_HLT = 4'hF;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with enable and synchronous clear; holds at all-ones
// instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/dmem_stage.sv
// MEM stage: issues the data-memory handshake from EX/MEM, stalls upstream while
// the memory is busy and fills MEM/WB. Define DMEM_TIMEOUT_EN for the wait timeout.
module dmem_stage
    import cpu_pkg::*;
#(
    parameter int DW = CPU_DW,
    parameter int AW = CPU_AW,
    parameter int RW = CPU_RW
`ifdef DMEM_TIMEOUT_EN
    ,
    parameter int TMO = 64
`endif
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ex_valid,
    input  logic          ex_mem_en,
    input  logic          ex_mem_wr,
    input  logic [AW-1:0] ex_result,
    input  logic [DW-1:0] ex_store_data,
    input  logic          ex_reg_wr,
    input  logic [15:0]   ex_inst,
    input  logic          ex_halt,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          stall_o,
    output logic          wb_valid,
    output logic          wb_reg_wr,
    output logic [RW-1:0] wb_dst,
    output logic [DW-1:0] wb_data,
    output logic [15:0]   wb_inst,
    output logic          wb_halt,
    output logic [15:0]   stall_cnt,
    output logic          err_o
);

    dmem_state_e state_q, state_d;
    mem_wb_t     wb_q, wb_d;
    logic        req;
    logic        stall;
    logic        capture;

`ifdef DMEM_TIMEOUT_EN
    logic        err_q, err_d;
    logic        timeout;
    logic [15:0] wait_cnt;

    sat_counter #(.W(16)) u_wait_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (state_q != WAIT),
        .en_i  ((state_q == WAIT) && stall),
        .cnt_o (wait_cnt)
    );
`endif

    // EX/MEM stays frozen while stalled, so the request is simply re-driven
    // from it every cycle until the ack arrives.
    always_comb begin
        state_d = state_q;
        wb_d    = '0;
        req     = 1'b0;
        stall   = 1'b0;
        capture = 1'b0;
`ifdef DMEM_TIMEOUT_EN
        timeout = 1'b0;
`endif
        case (state_q)
            IDLE, WAIT: begin
                state_d = IDLE;
                if (ex_valid && ex_mem_en) begin
                    req = 1'b1;
                    if (mem_ack) begin
                        capture = 1'b1;
                    end else begin
                        stall   = 1'b1;
                        state_d = WAIT;
`ifdef DMEM_TIMEOUT_EN
                        if ((state_q == WAIT) && (wait_cnt == 16'(TMO - 1))) begin
                            timeout = 1'b1;
                            state_d = HALTED;
                            wb_d.halt = 1'b1;
                        end
`endif
                    end
                end else if (ex_valid) begin
                    capture = 1'b1;
                    if (ex_halt) begin
                        state_d = HALTED;
                    end
                end
            end
            HALTED: begin
                stall     = 1'b1;
                wb_d.halt = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (capture) begin
            wb_d.valid  = 1'b1;
            wb_d.reg_wr = ex_reg_wr && !(ex_mem_en && ex_mem_wr);
            wb_d.dst    = ex_inst[11:8];
            wb_d.data   = (ex_mem_en && !ex_mem_wr) ? CPU_DW'(mem_rdata) : CPU_DW'(ex_result);
            wb_d.inst   = ex_inst;
            wb_d.halt   = ex_halt;
        end
    end

`ifdef DMEM_TIMEOUT_EN
    assign err_d = err_q || timeout;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            wb_q    <= '0;
        end else begin
            state_q <= state_d;
            wb_q    <= wb_d;
        end
    end

    // Halted cycles are not stalls waiting on memory, so they are not counted.
    sat_counter #(.W(16)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (1'b0),
        .en_i  (stall_o && (state_q != HALTED)),
        .cnt_o (stall_cnt)
    );

    assign mem_req   = req && rst_n;
    assign mem_we    = mem_req && ex_mem_wr;
    assign mem_addr  = ex_result;
    assign mem_wdata = ex_store_data;
    assign stall_o   = stall && rst_n;

    assign wb_valid  = wb_q.valid;
    assign wb_reg_wr = wb_q.reg_wr;
    assign wb_dst    = RW'(wb_q.dst);
    assign wb_data   = DW'(wb_q.data);
    assign wb_inst   = wb_q.inst;
    assign wb_halt   = wb_q.halt;

endmodule

// File: tb/tb_dmem_stage.sv
// Randomized self-checking bench for dmem_stage; the bench plays the data memory
// and predicts each instruction's stall/writeback from its chosen ack latency.
module tb_dmem_stage;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rstN;
    logic        exValid, exMemEn, exMemWr, exRegWr, exHalt;
    logic [15:0] exResult, exStoreData, exInst;
    logic        memReq, memWe, memAck;
    logic [15:0] memAddr, memWdata, memRdata;
    logic        stallO, wbValid, wbRegWr, wbHalt, errO;
    logic [3:0]  wbDst;
    logic [15:0] wbData, wbInst, stallCnt;

    int checks      = 0;
    int failures    = 0;
    int expStallCnt = 0;

    always #5 clk = ~clk;

`ifdef DMEM_TIMEOUT_EN
    dmem_stage #(.TMO(4)) dut (
`else
    dmem_stage dut (
`endif
        .clk           (clk),
        .rst_n         (rstN),
        .ex_valid      (exValid),
        .ex_mem_en     (exMemEn),
        .ex_mem_wr     (exMemWr),
        .ex_result     (exResult),
        .ex_store_data (exStoreData),
        .ex_reg_wr     (exRegWr),
        .ex_inst       (exInst),
        .ex_halt       (exHalt),
        .mem_req       (memReq),
        .mem_we        (memWe),
        .mem_addr      (memAddr),
        .mem_wdata     (memWdata),
        .mem_rdata     (memRdata),
        .mem_ack       (memAck),
        .stall_o       (stallO),
        .wb_valid      (wbValid),
        .wb_reg_wr     (wbRegWr),
        .wb_dst        (wbDst),
        .wb_data       (wbData),
        .wb_inst       (wbInst),
        .wb_halt       (wbHalt),
        .stall_cnt     (stallCnt),
        .err_o         (errO)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Entered and left 1 time unit after a rising edge.
    task automatic doReset();
        rstN    = 1'b0;
        exValid = 1'b0;
        exMemEn = 1'b0;
        exHalt  = 1'b0;
        memAck  = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rstN        = 1'b1;
        expStallCnt = 0;
        @(negedge clk);
        checkOutput("rst_wb_valid", 32'(wbValid), 32'd0);
        checkOutput("rst_wb_halt", 32'(wbHalt), 32'd0);
        checkOutput("rst_stall_cnt", 32'(stallCnt), 32'd0);
        checkOutput("rst_err", 32'(errO), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // kind: 0 = ALU op, 1 = load, 2 = store. lat = cycles without ack before the ack.
    task automatic applyStimulus(input int kind, input logic [15:0] result, input logic [15:0] sdata,
                                 input logic regWr, input logic [15:0] inst, input int latIn,
                                 input logic [15:0] rdata);
        logic        isMem, isStore;
        int          lat;
        logic [15:0] expData;
        isMem   = (kind != 0);
        isStore = (kind == 2);
        lat     = isMem ? latIn : 0;
        exValid = 1'b1;
        exMemEn = isMem;
        exMemWr = isStore;
        exResult = result;
        exStoreData = sdata;
        exRegWr = regWr;
        exInst  = inst;
        exHalt  = 1'b0;
        for (int c = 0; c <= lat; c++) begin
            memAck   = isMem && (c == lat);
            memRdata = (c == lat) ? rdata : 16'($urandom);
            @(negedge clk);
            checkOutput("mem_req", 32'(memReq), 32'(isMem));
            if (isMem) begin
                checkOutput("mem_we", 32'(memWe), 32'(isStore));
                checkOutput("mem_addr", 32'(memAddr), 32'(result));
                checkOutput("mem_wdata", 32'(memWdata), 32'(sdata));
            end
            checkOutput("stall", 32'(stallO), 32'(c != lat));
            checkOutput("bubble", 32'(wbValid), 32'd0);
            @(posedge clk);
            #1;
        end
        expStallCnt += lat;
        expData = (isMem && !isStore) ? rdata : result;
        // Idle cycle with a stray ack and junk memory fields that must be ignored.
        exValid = 1'b0;
        exMemEn = 1'($urandom_range(0, 1));
        memAck  = 1'($urandom_range(0, 1));
        @(negedge clk);
        checkOutput("wb_valid", 32'(wbValid), 32'd1);
        checkOutput("wb_reg_wr", 32'(wbRegWr), 32'(regWr && !isStore));
        checkOutput("wb_dst", 32'(wbDst), 32'(inst[11:8]));
        checkOutput("wb_data", 32'(wbData), 32'(expData));
        checkOutput("wb_inst", 32'(wbInst), 32'(inst));
        checkOutput("wb_halt", 32'(wbHalt), 32'd0);
        checkOutput("stall_cnt", 32'(stallCnt), 32'(expStallCnt));
        checkOutput("err", 32'(errO), 32'd0);
        checkOutput("idle_req", 32'(memReq), 32'd0);
        checkOutput("idle_stall", 32'(stallO), 32'd0);
        @(posedge clk);
        #1;
        memAck = 1'b0;
    endtask

    initial begin
        int          kind;
        logic [3:0]  op;
        exMemWr = 1'b0; exRegWr = 1'b0; exResult = '0; exStoreData = '0;
        exInst = '0; memRdata = '0;
        @(posedge clk);
        #1;
        doReset();

        $display("[TB] directed: ALU, zero-wait load, 3-wait store");
        applyStimulus(0, 16'h1234, 16'h0000, 1'b1, 16'h0312, 0, 16'h0000);
        applyStimulus(1, 16'h0010, 16'h0000, 1'b1, {OP_LW, 4'd5, 8'h10}, 0, 16'hBEEF);
        applyStimulus(2, 16'h0020, 16'h00AA, 1'b0, {OP_SW, 4'd2, 8'h20}, 3, 16'h5555);
        checkOutput("store_stall_cnt", 32'(stallCnt), 32'd3);

        $display("[TB] random instruction stream");
        for (int n = 0; n < 150; n++) begin
            kind = $urandom_range(0, 2);
            op   = (kind == 1) ? OP_LW : (kind == 2) ? OP_SW : 4'($urandom_range(0, 7));
            applyStimulus(kind, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
                          {op, 4'($urandom), 8'($urandom)}, $urandom_range(0, 4), 16'($urandom));
        end

        $display("[TB] reset during a waiting load");
        exValid = 1'b1; exMemEn = 1'b1; exMemWr = 1'b0; exHalt = 1'b0;
        exResult = 16'h0040; exInst = {OP_LW, 4'd7, 8'h40}; exRegWr = 1'b1; memAck = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rstN = 1'b0;
        @(negedge clk);
        checkOutput("rst_mid_req", 32'(memReq), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("rst_mid_wb_valid", 32'(wbValid), 32'd0);
        checkOutput("rst_mid_wb_reg_wr", 32'(wbRegWr), 32'd0);
        checkOutput("rst_mid_wb_data", 32'(wbData), 32'd0);
        checkOutput("rst_mid_wb_inst", 32'(wbInst), 32'd0);
        checkOutput("rst_mid_stall_cnt", 32'(stallCnt), 32'd0);
        @(posedge clk);
        #1;
        rstN = 1'b1; exValid = 1'b0; memAck = 1'b1; memRdata = 16'hDEAD;
        expStallCnt = 0;
        @(negedge clk);
        checkOutput("late_ack_req", 32'(memReq), 32'd0);
        checkOutput("late_ack_stall", 32'(stallO), 32'd0);
        @(posedge clk);
        #1;
        memAck = 1'b0;
        @(negedge clk);
        checkOutput("late_ack_wb_valid", 32'(wbValid), 32'd0);
        checkOutput("late_ack_stall_cnt", 32'(stallCnt), 32'd0);
        @(posedge clk);
        #1;

        $display("[TB] HLT after ADD");
        applyStimulus(0, 16'h0042, 16'h0000, 1'b1, 16'h0142, 0, 16'h0000);
        exValid = 1'b1; exMemEn = 1'b0; exHalt = 1'b1; exRegWr = 1'b0; exInst = {OP_HLT, 12'h000};
        @(negedge clk);
        checkOutput("hlt_stall", 32'(stallO), 32'd0);
        @(posedge clk);
        #1;
        exHalt = 1'b0; exMemEn = 1'b1; exMemWr = 1'b0; memAck = 1'b1;
        @(negedge clk);
        checkOutput("hlt_wb_valid", 32'(wbValid), 32'd1);
        checkOutput("hlt_wb_halt", 32'(wbHalt), 32'd1);
        checkOutput("hlt_wb_inst", 32'(wbInst), 32'(16'hF000));
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            checkOutput("halted_wb_halt", 32'(wbHalt), 32'd1);
            checkOutput("halted_wb_valid", 32'(wbValid), 32'd0);
            checkOutput("halted_stall", 32'(stallO), 32'd1);
            checkOutput("halted_req", 32'(memReq), 32'd0);
            checkOutput("halted_stall_cnt", 32'(stallCnt), 32'(expStallCnt));
        end
        @(posedge clk);
        #1;
        doReset();
        applyStimulus(0, 16'h0777, 16'h0000, 1'b1, 16'h0A77, 0, 16'h0000);

`ifdef DMEM_TIMEOUT_EN
        $display("[TB] timeout with TMO=4");
        doReset();
        exValid = 1'b1; exMemEn = 1'b1; exMemWr = 1'b0; exHalt = 1'b0;
        exResult = 16'h0080; exInst = {OP_LW, 4'd1, 8'h80}; exRegWr = 1'b1; memAck = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checkOutput("tmo_req", 32'(memReq), 32'd1);
            checkOutput("tmo_stall", 32'(stallO), 32'd1);
            checkOutput("tmo_err_early", 32'(errO), 32'd0);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        checkOutput("tmo_err", 32'(errO), 32'd1);
        checkOutput("tmo_wb_halt", 32'(wbHalt), 32'd1);
        checkOutput("tmo_wb_valid", 32'(wbValid), 32'd0);
        checkOutput("tmo_req_dropped", 32'(memReq), 32'd0);
        checkOutput("tmo_stall_cnt", 32'(stallCnt), 32'd5);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("tmo_err_sticky", 32'(errO), 32'd1);
        @(posedge clk);
        #1;
        doReset();
        applyStimulus(1, 16'h0080, 16'h0000, 1'b1, {OP_LW, 4'd1, 8'h80}, 4, 16'hCAFE);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
